// File: rtl/moxie_wb_arbiter_if.sv
// Bus bundle around the two-master / one-slave Wishbone arbiter.
// The slave modport is the arbiter's view. The master modport is the
// surrounding system: the two requesting masters plus the shared slave.
interface moxie_wb_arbiter_if;
    logic [31:0] m0_adr_i;
    logic [15:0] m0_dat_i;
    logic [15:0] m0_dat_o;
    logic [1:0]  m0_sel_i;
    logic        m0_we_i;
    logic        m0_cyc_i;
    logic        m0_stb_i;
    logic        m0_ack_o;
    logic        m0_err_o;

    logic [31:0] m1_adr_i;
    logic [15:0] m1_dat_i;
    logic [15:0] m1_dat_o;
    logic [1:0]  m1_sel_i;
    logic        m1_we_i;
    logic        m1_cyc_i;
    logic        m1_stb_i;
    logic        m1_ack_o;
    logic        m1_err_o;

    logic [31:0] s_adr_o;
    logic [15:0] s_dat_o;
    logic [15:0] s_dat_i;
    logic [1:0]  s_sel_o;
    logic        s_we_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic        s_ack_i;
    logic        s_err_i;

    logic [1:0]  gnt_o;

    modport slave (
        input  m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        output m0_dat_o, m0_ack_o, m0_err_o,
        input  m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        output m1_dat_o, m1_ack_o, m1_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i, s_err_i,
        output gnt_o
    );

    modport master (
        output m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i,
        input  m0_dat_o, m0_ack_o, m0_err_o,
        output m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i,
        input  m1_dat_o, m1_ack_o, m1_err_o,
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i, s_err_i,
        input  gnt_o
    );
endinterface

// File: rtl/moxie_wb_arbiter.sv
// Two-master Wishbone arbiter: registered grant held for the owner's whole
// cycle, fixed or round-robin priority, and a strobe watchdog that answers
// a stalled owner with a single err pulse.
module moxie_wb_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TO_WIDTH   = 8,
    parameter int TIMEOUT    = 255
) (
    input logic             clk_i,
    input logic             rst_i,
    moxie_wb_arbiter_if.slave wb
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam bit                TO_EN  = (TIMEOUT != 0);
    localparam logic [TO_WIDTH-1:0] TO_LIM = TO_WIDTH'(TIMEOUT);

    state_t              state_q, state_d;
    logic                last_q, last_d;      // index of the previous owner
    logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;

    logic        gnt0, gnt1;
    logic [31:0] own_adr;
    logic [15:0] own_dat;
    logic [1:0]  own_sel;
    logic        own_we, own_cyc, own_stb;
    logic        stb_raw, to_fire, s_stb;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // Grant, last-owner and watchdog registers; reset leaves master 0 favoured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next grant: arbitrate only from IDLE, release on the owner's cyc drop.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (wb.m0_cyc_i && wb.m1_cyc_i) begin
                    // last_q = 1 means master 1 had the bus last, so 0 goes next
                    state_d = (FIXED_PRIO || last_q) ? GNT0 : GNT1;
                end else if (wb.m0_cyc_i) begin
                    state_d = GNT0;
                end else if (wb.m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!wb.m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if (!wb.m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Owner mux toward the slave and the watchdog decision.
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        if (gnt0) begin
            own_adr = wb.m0_adr_i;
            own_dat = wb.m0_dat_i;
            own_sel = wb.m0_sel_i;
            own_we  = wb.m0_we_i;
            own_cyc = wb.m0_cyc_i;
            own_stb = wb.m0_stb_i;
        end else if (gnt1) begin
            own_adr = wb.m1_adr_i;
            own_dat = wb.m1_dat_i;
            own_sel = wb.m1_sel_i;
            own_we  = wb.m1_we_i;
            own_cyc = wb.m1_cyc_i;
            own_stb = wb.m1_stb_i;
        end
        stb_raw = own_stb & own_cyc;
        // A slave ack/err in the firing cycle wins over the timeout.
        to_fire = TO_EN && stb_raw && (to_cnt_q == TO_LIM)
                  && !wb.s_ack_i && !wb.s_err_i;
        s_stb   = stb_raw & ~to_fire;
        if (!TO_EN || (state_q == IDLE) || !s_stb || wb.s_ack_i || wb.s_err_i)
            to_cnt_d = '0;
        else
            to_cnt_d = to_cnt_q + 1'b1;
    end

    assign wb.s_adr_o = own_adr;
    assign wb.s_dat_o = own_dat;
    assign wb.s_sel_o = own_sel;
    assign wb.s_we_o  = own_we;
    assign wb.s_cyc_o = own_cyc;
    assign wb.s_stb_o = s_stb;

    assign wb.m0_dat_o = wb.s_dat_i;
    assign wb.m1_dat_o = wb.s_dat_i;
    assign wb.m0_ack_o = wb.s_ack_i & gnt0 & wb.m0_stb_i;
    assign wb.m1_ack_o = wb.s_ack_i & gnt1 & wb.m1_stb_i;
    assign wb.m0_err_o = (wb.s_err_i | to_fire) & gnt0 & wb.m0_stb_i;
    assign wb.m1_err_o = (wb.s_err_i | to_fire) & gnt1 & wb.m1_stb_i;

    assign wb.gnt_o = {gnt1, gnt0};
endmodule

// File: doc/moxie_wb_arbiter.md
Name: moxie_wb_arbiter

Overview:
Two-master, one-slave Wishbone arbiter with 16-bit data and 32-bit byte addresses. Master 0 is normally the moxielite CPU wrapper; master 1 is a secondary master such as DMA or debug. The block shares one slave/interconnect port between the two masters. It uses registered grant with fixed or round-robin priority, holds the grant for the whole cycle (while the owner's cyc is high), and has a bus-timeout watchdog that returns err to a stalled owner.

Parameters:
- FIXED_PRIO, default 0. 1 = master 0 always wins a contention; 0 = round-robin.
- TO_WIDTH, default 8. Width of the timeout counter.
- TIMEOUT, default 255. Cycles of unacknowledged strobe before err is returned; 0 disables the watchdog. Must be at most 2^TO_WIDTH-1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- m0_adr_i  in  32  master 0 address.
- m0_dat_i  in  16  master 0 write data.
- m0_dat_o  out  16  read data to master 0.
- m0_sel_i  in  2  master 0 byte selects.
- m0_we_i  in  1  master 0 write enable.
- m0_cyc_i  in  1  master 0 cycle.
- m0_stb_i  in  1  master 0 strobe.
- m0_ack_o  out  1  ack to master 0.
- m0_err_o  out  1  err to master 0.
- m1_*  (same nine ports as m0_*, same directions and widths)  master 1.
- s_adr_o  out  32  slave address.
- s_dat_o  out  16  slave write data.
- s_dat_i  in  16  slave read data.
- s_sel_o  out  2  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- gnt_o  out  2  one-hot current grant; 00 = idle.

Behaviour:
- State machine, all state registered. States:
  - IDLE (gnt 00)
  - GNT0 (gnt 01)
  - GNT1 (gnt 10)
- Reset, asynchronous:
  - State goes to IDLE, last-owner register = 1 (so master 0 wins the first round-robin contention), timeout counter = 0.
  - While in IDLE every s_* output and every m*_ack_o/m*_err_o is 0; gnt_o = 00.
- IDLE transitions:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high: if FIXED_PRIO=1 -> GNT0; else grant the master that was not the last owner.
  - Neither high -> stay IDLE.
- Grant latency: grant appears the cycle after cyc is first sampled high, so there is at least one wait cycle from cyc to slave stb.
- GNTn -> IDLE on the first clock where mn_cyc_i = 0; the last-owner register is updated to n. There is no direct GNT0<->GNT1 hop, so there is always one IDLE cycle between owners.
- Grant is never pre-empted. An owner keeping cyc high holds the bus indefinitely (block/RMW cycles).
- Slave side (combinational mux by gnt):
  - s_adr_o, s_dat_o, s_sel_o, s_we_o and s_cyc_o come from the owner.
  - s_stb_o = owner stb & owner cyc & ~to_fire.
  - All of the above are 0 when idle.
- Master side:
  - m0_dat_o = m1_dat_o = s_dat_i (broadcast).
  - mn_ack_o = s_ack_i & gntn & mn_stb_i. Ack is never routed to the non-owner.
  - mn_err_o = (s_err_i | to_fire) & gntn & mn_stb_i.
- Watchdog (only when TIMEOUT != 0):
  - Counter clears whenever s_stb_o = 0, s_ack_i = 1, s_err_i = 1, or the state is IDLE.
  - Otherwise it increments each clock.
  - to_fire = (counter == TIMEOUT), combinational. It produces exactly one err pulse to the owner and masks s_stb_o that cycle; the counter then clears.
  - Ack or err arriving in the same cycle as to_fire: ack/err from the slave takes precedence, ack_o is passed through, and no timeout err is raised.
- Owner drops cyc mid-transfer (abort): go to IDLE next clock; any late s_ack_i is not forwarded to anyone.
- A master raising cyc while the other owns the bus waits; its ack/err stays 0.

Test Plan:
1. Single master: reset, m0 read adr 0x100, slave acks after 2 wait states with 0xBEEF -> gnt_o 01 one cycle after cyc, m0_ack_o one pulse, m0_dat_o=0xBEEF, m1_ack_o=0, back to IDLE after cyc drops.
2. Contention, FIXED_PRIO=0: both assert cyc at the same clock, repeatedly, 4 transfers -> grants alternate 0,1,0,1 with one IDLE cycle between; with FIXED_PRIO=1 all go to m0 while m0 keeps requesting.
3. Block cycle: m1 holds cyc for 3 strobed writes (sel 10, 01, 11) while m0 requests -> m0 not granted until m1 drops cyc; s_sel_o matches each write.
4. Timeout: TIMEOUT=4, slave never acks -> m0_err_o single pulse exactly 4 cycles after s_stb_o rises, s_stb_o low that cycle; ack arriving on the 4th cycle -> ack only, no err.
5. Async reset mid-transfer while in GNT1 -> s_cyc_o/s_stb_o and gnt_o go to 0 immediately without a clock edge; after release, m0 wins a simultaneous request.
